// File: rtl/period_meter.sv
// rtl/period_meter.sv - measures the rising-edge-to-rising-edge period of a slow asynchronous signal in clk_in cycles
module period_meter #(
  parameter int W    = 24,
  parameter int SYNC = 2
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         sig_in,
  output logic [W-1:0] period,
  output logic         valid,
  output logic         edge_out,
  output logic         locked,
  output logic         timeout
);

  localparam logic [W-1:0] MAX = '1;

  typedef enum logic [1:0] {
    WAIT_FIRST,
    MEASURE,
    TIMEOUT
  } state_t;

  state_t         state;
  logic [W-1:0]   count;
  logic [SYNC-1:0] sync_q;
  logic           prev;
  logic           s_last;
  logic           rise;

  assign s_last = sync_q[SYNC-1];
  assign rise   = s_last & ~prev;

  // Synchroniser chain and edge-history flop; both preset high so a signal
  // already high at reset release must go low before any rise is seen.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync_q <= '1;
      prev   <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC-2:0], sig_in};
      prev   <= s_last;
    end
  end

  // Measurement FSM: counts cycles between rises, reports on each closing
  // rise and parks at MAX when an interval overflows.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state    <= WAIT_FIRST;
      count    <= '0;
      period   <= '0;
      valid    <= 1'b0;
      edge_out <= 1'b0;
      locked   <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      valid    <= 1'b0;
      edge_out <= rise;
      case (state)
        WAIT_FIRST: begin
          count <= '0;
          if (rise) begin
            count <= {{(W-1){1'b0}}, 1'b1};
            state <= MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            period <= count;
            valid  <= 1'b1;
            locked <= 1'b1;
            count  <= {{(W-1){1'b0}}, 1'b1};
          end else if (count == MAX) begin
            timeout <= 1'b1;
            locked  <= 1'b0;
            state   <= TIMEOUT;
          end else begin
            count <= count + 1'b1;
          end
        end
        TIMEOUT: begin
          count <= MAX;
          if (rise) begin
            timeout <= 1'b0;
            count   <= {{(W-1){1'b0}}, 1'b1};
            state   <= MEASURE;
          end
        end
        default: begin
          state <= WAIT_FIRST;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// tb/tb_period_meter.sv - directed vector bench for period_meter at W=24 and W=8
module tb_period_meter;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic        sig_a, sig_b;
  logic [23:0] period_a;
  logic [7:0]  period_b;
  logic        valid_a, edge_a, locked_a, timeout_a;
  logic        valid_b, edge_b, locked_b, timeout_b;

  always #5 clk = ~clk;

  period_meter #(.W(24), .SYNC(2)) dut_a (
    .clk_in   (clk),
    .rst      (rst_a),
    .sig_in   (sig_a),
    .period   (period_a),
    .valid    (valid_a),
    .edge_out (edge_a),
    .locked   (locked_a),
    .timeout  (timeout_a)
  );

  period_meter #(.W(8), .SYNC(2)) dut_b (
    .clk_in   (clk),
    .rst      (rst_b),
    .sig_in   (sig_b),
    .period   (period_b),
    .valid    (valid_b),
    .edge_out (edge_b),
    .locked   (locked_b),
    .timeout  (timeout_b)
  );

  typedef struct {
    int          hi;
    int          lo;
    int          reps;
    logic [23:0] exp_period;
  } vec_t;

  vec_t vecs[5];
  int   checks = 0;
  int   errors = 0;

  // Observers for instance A
  int          phase_a = 0;
  int          mphase_a = 0;
  logic [23:0] exp_a = '0;
  int          va_a = 0, ea_a = 0, bad_per_a = 0, dbl_a = 0, to_a = 0, lockdrop_a = 0;
  logic        pv_a = 1'b0, pe_a = 1'b0, seen_v_a = 1'b0;

  always @(negedge clk) begin
    if (phase_a != mphase_a) begin
      mphase_a = phase_a;
      seen_v_a = 1'b0;
    end
    if (valid_a) begin
      va_a++;
      if (period_a != exp_a) bad_per_a++;
      seen_v_a = 1'b1;
    end
    if (edge_a) ea_a++;
    if ((valid_a && pv_a) || (edge_a && pe_a)) dbl_a++;
    if (timeout_a) to_a++;
    if (seen_v_a && !locked_a) lockdrop_a++;
    pv_a = valid_a;
    pe_a = edge_a;
  end

  // Observers for instance B
  int   cyc_b = 0, last_edge_b = 0, to_rise_b = 0, to_delta_b = 0;
  logic to_locked_b = 1'b1, prev_to_b = 1'b0;
  int   vq_b[$];

  always @(negedge clk) begin
    cyc_b++;
    if (edge_b) last_edge_b = cyc_b;
    if (valid_b) vq_b.push_back(int'(period_b));
    if (timeout_b && !prev_to_b) begin
      to_rise_b++;
      to_delta_b  = cyc_b - last_edge_b;
      to_locked_b = locked_b;
    end
    prev_to_b = timeout_b;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_b(input int gap);
    sig_b = 1'b1;
    tick();
    sig_b = 1'b0;
    repeat (gap - 1) tick();
  endtask

  task automatic reset_b();
    sig_b = 1'b0;
    rst_b = 1'b1;
    tick();
    tick();
    rst_b = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    int b_va, b_ea, b_bad, b_dbl, b_to, b_ld, qbase, tobase, bad, tseen;

    vecs[0] = '{hi: 5,  lo: 5, reps: 5, exp_period: 24'd10};
    vecs[1] = '{hi: 1,  lo: 1, reps: 8, exp_period: 24'd2};
    vecs[2] = '{hi: 3,  lo: 4, reps: 5, exp_period: 24'd7};
    vecs[3] = '{hi: 12, lo: 3, reps: 4, exp_period: 24'd15};
    vecs[4] = '{hi: 1,  lo: 2, reps: 6, exp_period: 24'd3};

    rst_a = 1'b1;
    rst_b = 1'b1;
    sig_a = 1'b0;
    sig_b = 1'b0;
    repeat (3) tick();
    check("reset_a", {4'd0, period_a, valid_a, edge_a, locked_a, timeout_a}, 32'd0);
    check("reset_b", {20'd0, period_b, valid_b, edge_b, locked_b, timeout_b}, 32'd0);

    // Square-wave vectors on the wide instance, reset before each
    for (int i = 0; i < 5; i++) begin
      phase_a++;
      sig_a = 1'b0;
      rst_a = 1'b1;
      tick();
      tick();
      rst_a = 1'b0;
      exp_a = vecs[i].exp_period;
      b_va = va_a; b_ea = ea_a; b_bad = bad_per_a; b_dbl = dbl_a; b_to = to_a; b_ld = lockdrop_a;
      repeat (3) tick();
      for (int r = 0; r < vecs[i].reps; r++) begin
        sig_a = 1'b1;
        repeat (vecs[i].hi) tick();
        sig_a = 1'b0;
        repeat (vecs[i].lo) tick();
      end
      repeat (8) tick();
      check($sformatf("vec%0d_valids", i), va_a - b_va, vecs[i].reps - 1);
      check($sformatf("vec%0d_edges", i), ea_a - b_ea, vecs[i].reps);
      check($sformatf("vec%0d_bad_periods", i), bad_per_a - b_bad, 0);
      check($sformatf("vec%0d_back_to_back", i), dbl_a - b_dbl, 0);
      check($sformatf("vec%0d_timeout_cycles", i), to_a - b_to, 0);
      check($sformatf("vec%0d_lock_drops", i), lockdrop_a - b_ld, 0);
      check($sformatf("vec%0d_locked", i), locked_a, 1);
      check($sformatf("vec%0d_period", i), period_a, vecs[i].exp_period);
    end

    // sig_in high through reset and beyond never produces an edge
    phase_a++;
    sig_a = 1'b1;
    rst_a = 1'b1;
    tick();
    tick();
    rst_a = 1'b0;
    b_va = va_a; b_ea = ea_a; b_to = to_a;
    repeat (300) tick();
    check("held_high_edges", ea_a - b_ea, 0);
    check("held_high_valids", va_a - b_va, 0);
    check("held_high_locked", locked_a, 0);
    check("held_high_timeout", to_a - b_to, 0);

    // Reset in the middle of a locked interval
    phase_a++;
    sig_a = 1'b0;
    rst_a = 1'b1;
    tick();
    tick();
    rst_a = 1'b0;
    exp_a = 24'd10;
    repeat (3) tick();
    for (int r = 0; r < 3; r++) begin
      sig_a = 1'b1;
      repeat (5) tick();
      sig_a = 1'b0;
      repeat (5) tick();
    end
    repeat (2) tick();
    check("midrst_locked_before", locked_a, 1);
    check("midrst_period_before", period_a, 10);
    phase_a++;
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    check("midrst_period_zero", period_a, 0);
    check("midrst_locked_zero", locked_a, 0);
    b_va = va_a; b_ea = ea_a; b_bad = bad_per_a;
    repeat (3) tick();
    for (int r = 0; r < 2; r++) begin
      sig_a = 1'b1;
      repeat (5) tick();
      sig_a = 1'b0;
      repeat (5) tick();
    end
    repeat (8) tick();
    check("midrst_edges", ea_a - b_ea, 2);
    check("midrst_valids", va_a - b_va, 1);
    check("midrst_bad_periods", bad_per_a - b_bad, 0);
    check("midrst_period", period_a, 10);
    check("midrst_locked", locked_a, 1);

    // W=8: spacing of exactly MAX, then an overflowing gap, then recovery
    reset_b();
    qbase  = vq_b.size();
    tobase = to_rise_b;
    repeat (3) pulse_b(255);
    pulse_b(256);
    pulse_b(20);
    check("w8_valids_before_gap", vq_b.size() - qbase, 3);
    for (int k = 0; k < 3; k++) begin
      if (vq_b.size() > qbase + k) check($sformatf("w8_period255_%0d", k), vq_b[qbase + k], 255);
    end
    check("w8_timeout_rises", to_rise_b - tobase, 1);
    check("w8_timeout_delay", to_delta_b, 255);
    check("w8_locked_at_timeout", to_locked_b, 0);
    check("w8_timeout_cleared", timeout_b, 0);
    check("w8_unlocked_after_recover", locked_b, 0);
    check("w8_period_held", period_b, 255);
    sig_b = 1'b1;
    tick();
    sig_b = 1'b0;
    repeat (8) tick();
    check("w8_valids_total", vq_b.size() - qbase, 4);
    if (vq_b.size() > qbase + 3) check("w8_period20", vq_b[qbase + 3], 20);
    check("w8_relocked", locked_b, 1);
    check("w8_timeout_end", timeout_b, 0);

    // W=8: period holds through a long TIMEOUT stretch
    reset_b();
    qbase = vq_b.size();
    repeat (2) pulse_b(20);
    sig_b = 1'b1;
    tick();
    sig_b = 1'b0;
    bad   = 0;
    tseen = 0;
    repeat (299) begin
      tick();
      if (timeout_b) tseen++;
      if (period_b != 8'd20) bad++;
    end
    sig_b = 1'b1;
    tick();
    sig_b = 1'b0;
    repeat (8) tick();
    check("hold_period_bad_cycles", bad, 0);
    check("hold_timeout_seen", (tseen > 0) ? 1 : 0, 1);
    check("hold_valids", vq_b.size() - qbase, 2);
    check("hold_period_final", period_b, 20);
    check("hold_timeout_final", timeout_b, 0);
    check("hold_locked_final", locked_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
